// File: rtl/pe_pkg.sv
// Shared types and constants for the PE operand/partial-sum distribution blocks.
package pe_pkg;

   typedef enum logic [1:0] {
      STEER = 2'd0,
      RR    = 2'd1,
      BCAST = 2'd2,
      RSVD  = 2'd3
   } pe_dmux_mode_e;

   localparam int PE_DMUX_W_DEF = 24;
   localparam int PE_DMUX_N_DEF = 4;
   localparam int PE_DMUX_N_MAX = 16;

endpackage

// File: rtl/pe_dmux_slot.sv
// One-entry output register for a single demux lane; the output reads zero whenever the lane is idle.
module pe_dmux_slot
   import pe_pkg::*;
#(
   parameter int W = PE_DMUX_W_DEF
)
(
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] din,
   input  logic         ready,
   output logic         valid,
   output logic         free,
   output logic [W-1:0] dout
);

   logic [W-1:0] data;

   // A refill takes priority over a drain, so a lane can stream back-to-back beats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= din;
      end else if (valid && ready) begin
         valid <= 1'b0;
         data  <= '0;
      end
   end

   assign free = !valid || ready;
   assign dout = valid ? data : '0;

endmodule

// File: rtl/pe_dmux_n.sv
// Registered 1-to-N demux feeding PE lanes, with steer, round-robin and broadcast modes.
module pe_dmux_n
   import pe_pkg::*;
#(
   parameter int W    = PE_DMUX_W_DEF,
   parameter int N    = PE_DMUX_N_DEF,
   parameter int SELW = (N > 1) ? $clog2(N) : 1
)
(
   input  logic            clk,
   input  logic            rst,
   input  logic [W-1:0]    din,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SELW-1:0] sel,
   input  logic [1:0]      mode,
   output logic [N*W-1:0]  dout,
   output logic [N-1:0]    out_valid,
   input  logic [N-1:0]    out_ready,
   output logic [SELW-1:0] rr_ptr,
   output logic            err_sel,
   input  logic            err_clr
);

   pe_dmux_mode_e mode_e;
   logic [N-1:0]  tgt;
   logic [N-1:0]  free;
   logic [N-1:0]  load;
   logic          sel_bad;
   logic          accept;

   assign mode_e = pe_dmux_mode_e'(mode);

   // An out-of-range steer leaves the target set empty, so the beat is accepted and dropped.
   always_comb begin
      tgt     = '0;
      sel_bad = 1'b0;
      case (mode_e)
         RR: begin
            for (int k = 0; k < N; k++) tgt[k] = (int'(rr_ptr) == k);
         end
         BCAST: begin
            tgt = '1;
         end
         default: begin
            sel_bad = (int'(sel) >= N);
            for (int k = 0; k < N; k++) tgt[k] = (int'(sel) == k);
         end
      endcase
   end

   assign in_ready = &(free | ~tgt);
   assign accept   = in_valid && in_ready;
   assign load     = tgt & {N{accept}};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (accept && mode_e == RR) begin
         rr_ptr <= (int'(rr_ptr) == N - 1) ? '0 : rr_ptr + SELW'(1);
      end
   end

   // Clearing wins over a fresh bad select in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_sel <= 1'b0;
      end else if (err_clr) begin
         err_sel <= 1'b0;
      end else if (accept && sel_bad) begin
         err_sel <= 1'b1;
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_slot
      pe_dmux_slot #(.W(W)) u_slot (
         .clk   (clk),
         .rst   (rst),
         .load  (load[k]),
         .din   (din),
         .ready (out_ready[k]),
         .valid (out_valid[k]),
         .free  (free[k]),
         .dout  (dout[k*W +: W])
      );
   end

endmodule

// File: tb/tb_pe_dmux_n.sv
// Scoreboard bench for pe_dmux_n: per-lane expected queues fed by a reference model, drained by a monitor.
module tb_pe_dmux_n;

   localparam int W  = 24;
   localparam int N  = 4;
   localparam int SW = 2;
   localparam int N3 = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [W-1:0]    din = '0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [SW-1:0]   sel = '0;
   logic [1:0]      mode = 2'd0;
   logic [N*W-1:0]  dout;
   logic [N-1:0]    out_valid;
   logic [N-1:0]    out_ready = '0;
   logic [SW-1:0]   rr_ptr;
   logic            err_sel;
   logic            err_clr = 1'b0;

   logic [W-1:0]    b_din = '0;
   logic            b_in_valid = 1'b0;
   logic            b_in_ready;
   logic [SW-1:0]   b_sel = '0;
   logic [1:0]      b_mode = 2'd0;
   logic [N3*W-1:0] b_dout;
   logic [N3-1:0]   b_out_valid;
   logic [N3-1:0]   b_out_ready = '1;
   logic [SW-1:0]   b_rr_ptr;
   logic            b_err_sel;
   logic            b_err_clr = 1'b0;

   int tests_run = 0;
   int tests_failed = 0;

   logic [W-1:0] exp_q [N][$];
   int           rr_exp = 0;
   logic         err_exp = 1'b0;
   int           tgts[$];
   logic         exp_rdy;
   logic         bad;
   logic         mon_v;
   logic [W-1:0] mon_d;

   always #5 clk = ~clk;

   pe_dmux_n #(.W(W), .N(N)) dut (
      .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(in_ready),
      .sel(sel), .mode(mode), .dout(dout), .out_valid(out_valid), .out_ready(out_ready),
      .rr_ptr(rr_ptr), .err_sel(err_sel), .err_clr(err_clr)
   );

   pe_dmux_n #(.W(W), .N(N3)) dut3 (
      .clk(clk), .rst(rst), .din(b_din), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .sel(b_sel), .mode(b_mode), .dout(b_dout), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .rr_ptr(b_rr_ptr), .err_sel(b_err_sel), .err_clr(b_err_clr)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic [1:0] s,
                                input logic [1:0] m, input logic [N-1:0] r);
      in_valid  = v;
      din       = d;
      sel       = s;
      mode      = m;
      out_ready = r;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every queued beat must be on its lane; it is retired when the lane's ready is high.
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < N; k++) begin
            mon_v = exp_q[k].size() > 0;
            mon_d = mon_v ? exp_q[k][0] : '0;
            checkOutput($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(mon_v));
            checkOutput($sformatf("dout[%0d]", k), 32'(dout[k*W +: W]), 32'(mon_d));
            if (mon_v && out_ready[k]) void'(exp_q[k].pop_front());
         end
         checkOutput("rr_ptr", 32'(rr_ptr), 32'(rr_exp));
         checkOutput("err_sel", 32'(err_sel), 32'(err_exp));
      end
   end

   // Reference model: a lane is busy while it still owns an undelivered beat.
   always begin
      @(negedge clk);
      #1;
      if (!rst) begin
         tgts.delete();
         bad = 1'b0;
         case (mode)
            2'd1: tgts.push_back(rr_exp);
            2'd2: for (int k = 0; k < N; k++) tgts.push_back(k);
            default: if (int'(sel) < N) tgts.push_back(int'(sel)); else bad = 1'b1;
         endcase
         exp_rdy = 1'b1;
         foreach (tgts[i]) if (exp_q[tgts[i]].size() != 0) exp_rdy = 1'b0;
         checkOutput("in_ready", 32'(in_ready), 32'(exp_rdy));
         if (in_valid && exp_rdy) begin
            foreach (tgts[i]) exp_q[tgts[i]].push_back(din);
            if (mode == 2'd1) rr_exp = (rr_exp + 1) % N;
         end
         if (err_clr) err_exp = 1'b0;
         else if (in_valid && exp_rdy && bad) err_exp = 1'b1;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(1'b0, '0, 2'd0, 2'd0, 4'b1111);
      checkOutput("reset out_valid", 32'(out_valid), 32'h0);
      checkOutput("reset dout zero", 32'(dout == '0), 32'h1);
      checkOutput("reset rr_ptr", 32'(rr_ptr), 32'h0);
      checkOutput("reset err_sel", 32'(err_sel), 32'h0);

      applyStimulus(1'b1, 24'hABCDEF, 2'd2, 2'd0, 4'b1111);
      tick();
      applyStimulus(1'b0, '0, 2'd0, 2'd0, 4'b0000);
      checkOutput("steer out_valid", 32'(out_valid), 32'h4);
      checkOutput("steer dout[2]", 32'(dout[2*W +: W]), 32'hABCDEF);
      checkOutput("steer dout[0]", 32'(dout[0 +: W]), 32'h0);
      tick();
      applyStimulus(1'b0, '0, 2'd0, 2'd0, 4'b1111);
      tick();

      applyStimulus(1'b1, 24'h11, 2'd1, 2'd0, 4'b1101);
      tick();
      applyStimulus(1'b1, 24'h22, 2'd1, 2'd0, 4'b1101);
      checkOutput("bp in_ready low", 32'(in_ready), 32'h0);
      checkOutput("bp dout[1] hold", 32'(dout[W +: W]), 32'h11);
      tick();
      applyStimulus(1'b1, 24'h22, 2'd1, 2'd0, 4'b1101);
      checkOutput("bp dout[1] stable", 32'(dout[W +: W]), 32'h11);
      applyStimulus(1'b1, 24'h22, 2'd1, 2'd0, 4'b1111);
      checkOutput("bp in_ready release", 32'(in_ready), 32'h1);
      tick();
      applyStimulus(1'b0, '0, 2'd0, 2'd0, 4'b0000);
      checkOutput("bp no bubble", 32'(dout[W +: W]), 32'h22);
      tick();
      applyStimulus(1'b0, '0, 2'd0, 2'd0, 4'b1111);
      tick();

      for (int i = 1; i <= 6; i++) begin
         applyStimulus(1'b1, W'(i), 2'd0, 2'd1, 4'b1111);
         tick();
      end
      applyStimulus(1'b0, '0, 2'd0, 2'd1, 4'b1111);
      checkOutput("rr end ptr", 32'(rr_ptr), 32'h2);
      applyStimulus(1'b1, 24'h7, 2'd0, 2'd1, 4'b1011);
      tick();
      for (int i = 8; i <= 10; i++) begin
         applyStimulus(1'b1, W'(i), 2'd0, 2'd1, 4'b1011);
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 24'hB, 2'd0, 2'd1, 4'b1011);
         checkOutput("rr stall in_ready", 32'(in_ready), 32'h0);
         checkOutput("rr stall ptr", 32'(rr_ptr), 32'h2);
         tick();
      end
      applyStimulus(1'b1, 24'hB, 2'd0, 2'd1, 4'b1111);
      tick();
      applyStimulus(1'b0, '0, 2'd0, 2'd0, 4'b1111);
      tick();

      applyStimulus(1'b1, 24'h33, 2'd0, 2'd0, 4'b1110);
      tick();
      applyStimulus(1'b1, 24'h5A5A5A, 2'd0, 2'd2, 4'b1110);
      checkOutput("bcast blocked", 32'(in_ready), 32'h0);
      tick();
      applyStimulus(1'b1, 24'h5A5A5A, 2'd0, 2'd2, 4'b1111);
      checkOutput("bcast released", 32'(in_ready), 32'h1);
      tick();
      applyStimulus(1'b0, '0, 2'd0, 2'd0, 4'b0000);
      checkOutput("bcast out_valid", 32'(out_valid), 32'hF);
      for (int k = 0; k < N; k++)
         checkOutput($sformatf("bcast dout[%0d]", k), 32'(dout[k*W +: W]), 32'h5A5A5A);
      tick();
      applyStimulus(1'b0, '0, 2'd0, 2'd0, 4'b1111);
      tick();

      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), W'($urandom), 2'($urandom_range(0, 3)),
                       2'($urandom_range(0, 3)), 4'($urandom));
         tick();
      end

      applyStimulus(1'b1, 24'h44, 2'd0, 2'd1, 4'b1111);
      tick();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, W'(24'h100 + k), 2'(k), 2'd0, 4'b0000);
         tick();
      end
      applyStimulus(1'b0, '0, 2'd0, 2'd0, 4'b0000);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("async rst out_valid", 32'(out_valid), 32'h0);
      checkOutput("async rst dout zero", 32'(dout == '0), 32'h1);
      checkOutput("async rst rr_ptr", 32'(rr_ptr), 32'h0);
      for (int k = 0; k < N; k++) exp_q[k].delete();
      rr_exp = 0;
      err_exp = 1'b0;
      tick();
      rst = 1'b0;
      applyStimulus(1'b1, 24'h77, 2'd3, 2'd1, 4'b0000);
      tick();
      applyStimulus(1'b0, '0, 2'd0, 2'd0, 4'b0000);
      checkOutput("post rst rr lane", 32'(out_valid), 32'h1);
      tick();
      applyStimulus(1'b0, '0, 2'd0, 2'd0, 4'b1111);
      tick();

      b_in_valid = 1'b1;
      b_sel = 2'd3;
      b_mode = 2'd0;
      b_din = 24'hDEAD;
      #1;
      checkOutput("bad sel in_ready", 32'(b_in_ready), 32'h1);
      tick();
      checkOutput("bad sel dropped", 32'(b_out_valid), 32'h0);
      checkOutput("bad sel err", 32'(b_err_sel), 32'h1);
      b_sel = 2'd2;
      b_din = 24'h123;
      b_out_ready = 3'b000;
      tick();
      b_in_valid = 1'b0;
      #1;
      checkOutput("n3 lane2 valid", 32'(b_out_valid), 32'h4);
      checkOutput("n3 lane2 data", 32'(b_dout[2*W +: W]), 32'h123);
      checkOutput("err sticky", 32'(b_err_sel), 32'h1);
      b_out_ready = 3'b111;
      b_in_valid = 1'b1;
      b_sel = 2'd3;
      b_err_clr = 1'b1;
      tick();
      b_in_valid = 1'b0;
      b_err_clr = 1'b0;
      #1;
      checkOutput("err clr priority", 32'(b_err_sel), 32'h0);
      tick();
      checkOutput("err stays clear", 32'(b_err_sel), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
